phase_noise_source: RTL

Digital test-signal source that drives the analyzer's PLL input. It runs a sample-rate direct digital synthesizer (24-bit phase accumulator, quarter-wave sine LUT) and injects a programmable static phase offset plus pseudo-random phase noise. The injected phase is output alongside the signal as a known truth reference, so the recovered phase can be compared against it. It sits upstream of the PLL, clocked on the same `tick_i` sample strobe.

---
 rtl/phase_noise_source.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/phase_noise_source.sv
// phase_noise_source
//   Sample-rate DDS test source with programmable static phase offset and
//   LFSR phase noise. The injected phase (offset + noise) is output next to
//   the sine sample as a truth reference for the downstream PLL.
//
// Ports
//   clk_i, rst_i        system clock, asynchronous active-low reset
//   tick_i              one-cycle sample strobe (back-to-back legal)
//   cfg_valid_i/ready_o configuration handshake; applied at the next tick
//   cfg_freq_i          frequency tuning word (unsigned, ACC_W bits)
//   cfg_pm_i            static phase offset (two's complement, 2*pi full scale)
//   cfg_noise_i         noise shift, 0 disables noise
//   signal_o            signed sine sample
//   phase_o             signed injected phase aligned with signal_o
//   valid_o             one-cycle pulse, 4 cycles after the tick
module phase_noise_source #(
  parameter int ACC_W  = 24,
  parameter int LUT_AW = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               tick_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [ACC_W-1:0]   cfg_freq_i,
  input  logic [15:0]        cfg_pm_i,
  input  logic [3:0]         cfg_noise_i,
  output logic signed [15:0] signal_o,
  output logic signed [15:0] phase_o,
  output logic               valid_o
);

  localparam int LUT_N  = 1 << LUT_AW;
  localparam int STAGES = 3;

  typedef struct packed {
    logic [ACC_W-1:0] freq;
    logic [15:0]      pm;
    logic [3:0]       nsh;
  } cfg_t;

  // Quarter-wave entry k = round(32767*sin(pi/2*(k+0.5)/LUT_N)).
  // Taylor series in Q60 fixed point; pi/2 is carried as a Q30 constant,
  // which keeps the result far below half an output LSB.
  function automatic logic [15:0] lut_val(input int k);
    logic signed [127:0] x, x2, term, sum;
    x    = ((128'sd1686629713 <<< 30) * 128'(2*k + 1)) / 128'(2*LUT_N);
    x2   = (x * x) >>> 60;
    term = x;
    sum  = x;
    for (int n = 1; n <= 10; n++) begin
      term = -((term * x2) >>> 60) / 128'((2*n) * (2*n + 1));
      sum  = sum + term;
    end
    sum = (sum * 128'sd32767 + (128'sd1 <<< 59)) >>> 60;
    return sum[15:0];
  endfunction

  logic [15:0] lut_rom [LUT_N];
  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam logic [15:0] V = lut_val(k);
    assign lut_rom[k] = V;
  end

  cfg_t              shadow, act;
  logic [ACC_W-1:0]  acc;
  logic [15:0]       lfsr;
  logic [STAGES:0]   vld_pipe;

  logic signed [15:0] noise;
  logic [15:0]        inj, p;
  logic               phase_frac_unused;

  logic [LUT_AW+1:0]  s1_p;
  logic [15:0]        s1_inj;
  logic [LUT_AW-1:0]  s2_addr;
  logic               s2_neg;
  logic [15:0]        s2_inj;

  // Config: shadow is written on transfer and copied to the active set at
  // the first tick while the slot is occupied (necessarily a later cycle).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      shadow      <= '0;
      act         <= '0;
      cfg_ready_o <= 1'b1;
    end else if (cfg_ready_o) begin
      if (cfg_valid_i) begin
        shadow      <= '{freq: cfg_freq_i, pm: cfg_pm_i, nsh: cfg_noise_i};
        cfg_ready_o <= 1'b0;
      end
    end else if (tick_i) begin
      act         <= shadow;
      cfg_ready_o <= 1'b1;
    end
  end

  // Stage 0: accumulator and Galois LFSR (right shift, mask 0xB400).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc  <= '0;
      lfsr <= 16'hACE1;
    end else if (tick_i) begin
      acc  <= acc + act.freq;
      lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
    end
  end

  // Stage 1 math reads post-tick acc/lfsr and the active config, so the
  // applying tick's sample already carries the new offset and noise.
  assign noise = (act.nsh == 4'd0) ? 16'sd0 : ($signed(lfsr) >>> act.nsh);
  assign inj   = act.pm + noise;
  assign p     = acc[ACC_W-1 -: 16] + inj;
  // Phase bits below LUT resolution only feed the carry into the index.
  assign phase_frac_unused = ^p[13-LUT_AW:0];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_pipe <= '0;
      s1_p     <= '0;
      s1_inj   <= '0;
      s2_addr  <= '0;
      s2_neg   <= 1'b0;
      s2_inj   <= '0;
      signal_o <= '0;
      phase_o  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], tick_i};
      if (vld_pipe[0]) begin
        s1_p   <= p[15 -: LUT_AW+2];
        s1_inj <= inj;
      end
      // Stage 2: odd quadrants walk the quarter wave backwards (~i == max-i).
      if (vld_pipe[1]) begin
        s2_addr <= s1_p[LUT_AW] ? ~s1_p[LUT_AW-1:0] : s1_p[LUT_AW-1:0];
        s2_neg  <= s1_p[LUT_AW+1];
        s2_inj  <= s1_inj;
      end
      // Stage 3: LUT read merged with the sign/output register to meet the
      // 4-cycle tick-to-valid latency. Outputs hold between samples.
      if (vld_pipe[2]) begin
        signal_o <= s2_neg ? -$signed(lut_rom[s2_addr]) : $signed(lut_rom[s2_addr]);
        phase_o  <= s2_inj;
      end
    end
  end

  assign valid_o = vld_pipe[STAGES];

endmodule
